// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse transmit path.
//   - letter code constants (A = 0 ... Z = 25, 26 = word space)
//   - encoder state enumeration
//   - duration multipliers, in Morse units, for each keyed/gap period
//   - ROM entry layout {len, pat}: pat is MSB-first, bit = 1 means dash
// Optional feature macro used by the encoder: MORSE_ERR_EN.
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam logic [4:0] LTR_A     = 5'd0;
  localparam logic [4:0] LTR_SPACE = 5'd26;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SYM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  localparam int unsigned MUL_DOT      = 1;
  localparam int unsigned MUL_DASH     = 3;
  localparam int unsigned MUL_SYM_GAP  = 1;
  localparam int unsigned MUL_CHAR_GAP = 3;
  // Word gap follows a character gap, so 3 + 4 = 7 units of silence total.
  localparam int unsigned MUL_WORD_GAP = 4;

  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pat;
  } morse_sym_t;

  // Length of the current state in Morse units; 'dash' selects the mark length.
  function automatic int unsigned state_units(input state_t st, input logic dash);
    int unsigned u;
    u = 1;
    case (st)
      MARK:     u = dash ? MUL_DASH : MUL_DOT;
      SYM_GAP:  u = MUL_SYM_GAP;
      CHAR_GAP: u = MUL_CHAR_GAP;
      WORD_GAP: u = MUL_WORD_GAP;
      default:  u = 1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// -----------------------------------------------------------------------------
// morse_rom
// Combinational letter-code to Morse pattern lookup.
// Ports:
//   code  in   5  letter code (0..25 = A..Z)
//   sym   out  7  {len[2:0], pat[3:0]}; pat MSB-first, 1 = dash.
//                 Any code outside A..Z (including the word space) gives len 0.
// -----------------------------------------------------------------------------
module morse_rom
  import morse_pkg::*;
(
  input  logic [4:0] code,
  output morse_sym_t sym
);

  always_comb begin
    sym = '0;
    case (code)
      LTR_A: sym = {3'd2, 4'b0100};  // .-
      5'd1:  sym = {3'd4, 4'b1000};  // -...
      5'd2:  sym = {3'd4, 4'b1010};  // -.-.
      5'd3:  sym = {3'd3, 4'b1000};  // -..
      5'd4:  sym = {3'd1, 4'b0000};  // .
      5'd5:  sym = {3'd4, 4'b0010};  // ..-.
      5'd6:  sym = {3'd3, 4'b1100};  // --.
      5'd7:  sym = {3'd4, 4'b0000};  // ....
      5'd8:  sym = {3'd2, 4'b0000};  // ..
      5'd9:  sym = {3'd4, 4'b0111};  // .---
      5'd10: sym = {3'd3, 4'b1010};  // -.-
      5'd11: sym = {3'd4, 4'b0100};  // .-..
      5'd12: sym = {3'd2, 4'b1100};  // --
      5'd13: sym = {3'd2, 4'b1000};  // -.
      5'd14: sym = {3'd3, 4'b1110};  // ---
      5'd15: sym = {3'd4, 4'b0110};  // .--.
      5'd16: sym = {3'd4, 4'b1101};  // --.-
      5'd17: sym = {3'd3, 4'b0100};  // .-.
      5'd18: sym = {3'd3, 4'b0000};  // ...
      5'd19: sym = {3'd1, 4'b1000};  // -
      5'd20: sym = {3'd3, 4'b0010};  // ..-
      5'd21: sym = {3'd4, 4'b0001};  // ...-
      5'd22: sym = {3'd3, 4'b0110};  // .--
      5'd23: sym = {3'd4, 4'b1001};  // -..-
      5'd24: sym = {3'd4, 4'b1011};  // -.--
      5'd25: sym = {3'd4, 4'b1100};  // --..
      default: sym = '0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// -----------------------------------------------------------------------------
// morse_encoder
// Converts letter codes into an on/off keyed Morse stream.
// Timing unit is UNIT_CYCLES clocks: dot 1U, dash 3U, symbol gap 1U,
// character gap 3U, extra word gap 4U (7U of silence after a letter).
// Ports:
//   clk     in   1  system clock (posedge)
//   rst     in   1  synchronous active-high reset
//   valid   in   1  letter presented
//   letter  in   5  0..25 = A..Z, 26 = word space, 27..31 = invalid
//   ready   out  1  letter accepted this cycle if valid
//   out     out  1  keyed stream, 1 = mark (registered)
//   busy    out  1  state is not IDLE
//   err     out  1  (only with MORSE_ERR_EN) one-cycle pulse after an
//                   invalid code is accepted
// Optional feature macro: MORSE_ERR_EN.
// -----------------------------------------------------------------------------
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1,
  parameter int CNT_W       = $clog2(3*UNIT_CYCLES+1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [4:0] letter,
  output logic       ready,
  output logic       out,
  output logic       busy
`ifdef MORSE_ERR_EN
  ,
  output logic       err
`endif
);

  // The word gap lasts 4U, which can exceed what CNT_W holds for some U,
  // so the counter is widened when needed.
  localparam int NEED_W = (MUL_WORD_GAP*UNIT_CYCLES > 1) ? $clog2(MUL_WORD_GAP*UNIT_CYCLES) : 1;
  localparam int CW     = (CNT_W > NEED_W) ? CNT_W : NEED_W;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [3:0]     pat_reg, pat_next;
  logic [2:0]     len_reg, len_next;
  logic           out_reg;

  morse_sym_t     sym;
  logic           accept;
  logic           last_cycle;
  logic           ready_int;
  logic [CW-1:0]  dur_m1;

  morse_rom u_rom (
    .code (letter),
    .sym  (sym)
  );

  // Final count of the current state; pat_reg[3] is always the symbol being keyed.
  assign dur_m1     = CW'(state_units(state_reg, pat_reg[3]) * UNIT_CYCLES - 1);
  assign last_cycle = (cnt_reg == dur_m1);

  // Opening ready in the final gap cycle lets back-to-back letters see exactly
  // 3U / 7U of silence. ready is held low while reset is asserted.
  assign ready_int = (state_reg == IDLE) ||
                     (((state_reg == CHAR_GAP) || (state_reg == WORD_GAP)) && last_cycle);
  assign ready     = ready_int && !rst;
  assign accept    = valid && ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    pat_next   = pat_reg;
    len_next   = len_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
      end
      MARK: begin
        if (last_cycle) begin
          cnt_next = '0;
          if (len_reg > 3'd1) begin
            state_next = SYM_GAP;
            pat_next   = pat_reg << 1;
            len_next   = len_reg - 3'd1;
          end else begin
            state_next = CHAR_GAP;
          end
        end
      end
      SYM_GAP: begin
        if (last_cycle) begin
          cnt_next   = '0;
          state_next = MARK;
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (last_cycle) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    // An accept overrides the normal exit of IDLE or a finishing gap.
    if (accept) begin
      cnt_next = '0;
      pat_next = sym.pat;
      len_next = sym.len;
      if (letter == LTR_SPACE) begin
        state_next = WORD_GAP;
      end else if (sym.len != 3'd0) begin
        state_next = MARK;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pat_reg   <= '0;
      len_reg   <= '0;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      out_reg   <= (state_next == MARK);
    end
  end

  assign out  = out_reg;
  assign busy = (state_reg != IDLE);

`ifdef MORSE_ERR_EN
  logic err_reg;

  // Invalid codes have len 0 and are not the word space.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= accept && (letter != LTR_SPACE) && (sym.len == 3'd0);
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_morse_encoder.sv
// -----------------------------------------------------------------------------
// tb_morse_encoder
// Scoreboard bench for morse_encoder. Two instances: u1 with UNIT_CYCLES=1,
// u2 with UNIT_CYCLES=2. Stimulus pushes the expected per-cycle
// {out, ready, busy, err} into a per-instance queue; a monitor pops one entry
// per cycle on the falling edge and compares. Honours MORSE_ERR_EN.
// -----------------------------------------------------------------------------
module tb_morse_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic [4:0] l1 = '0,   l2 = '0;
  logic       r1, o1, b1, r2, o2, b2;
  logic       err1_w, err2_w;

  always #5 clk = ~clk;

`ifdef MORSE_ERR_EN
  logic e1, e2;
  assign err1_w = e1;
  assign err2_w = e2;
`else
  assign err1_w = 1'b0;
  assign err2_w = 1'b0;
`endif

  morse_encoder #(.UNIT_CYCLES(1)) u1 (
    .clk    (clk),
    .rst    (rst),
    .valid  (v1),
    .letter (l1),
    .ready  (r1),
    .out    (o1),
    .busy   (b1)
`ifdef MORSE_ERR_EN
    ,
    .err    (e1)
`endif
  );

  morse_encoder #(.UNIT_CYCLES(2)) u2 (
    .clk    (clk),
    .rst    (rst),
    .valid  (v2),
    .letter (l2),
    .ready  (r2),
    .out    (o2),
    .busy   (b2)
`ifdef MORSE_ERR_EN
    ,
    .err    (e2)
`endif
  );

  typedef struct {
    logic  o;
    logic  r;
    logic  b;
    logic  e;
    string name;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  int   tests  = 0;
  int   errors = 0;

  task automatic push_run(input int dut, input int n, input logic o, input logic r,
                          input logic b, input logic e, input string name);
    exp_t x;
    x.o = o; x.r = r; x.b = b; x.e = e; x.name = name;
    for (int i = 0; i < n; i++) begin
      if (dut == 1) sb1.push_back(x);
      else          sb2.push_back(x);
    end
  endtask

  // Expected stream for one letter given as dots/dashes, unit length u.
  task automatic push_char(input int dut, input int u, input string pat, input string name);
    for (int i = 0; i < pat.len(); i++) begin
      if (i > 0) push_run(dut, u, 1'b0, 1'b0, 1'b1, 1'b0, name);
      push_run(dut, (pat[i] == "-") ? 3*u : u, 1'b1, 1'b0, 1'b1, 1'b0, name);
    end
    push_run(dut, 3*u - 1, 1'b0, 1'b0, 1'b1, 1'b0, name);
    push_run(dut, 1,       1'b0, 1'b1, 1'b1, 1'b0, name);
  endtask

  task automatic check(input int dut, input exp_t x, input logic o, input logic r,
                       input logic b, input logic e);
    tests++;
    if ({o, r, b} !== {x.o, x.r, x.b}) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got out/ready/busy=%b%b%b, want %b%b%b",
               x.name, dut, $time, o, r, b, x.o, x.r, x.b);
    end
`ifdef MORSE_ERR_EN
    tests++;
    if (e !== x.e) begin
      errors++;
      $display("FAIL %s_err dut%0d t=%0t: got err=%b, want %b", x.name, dut, $time, e, x.e);
    end
`else
    if (e !== 1'b0) $display("[TB] note: err tie-off nonzero");
`endif
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (sb1.size() > 0) begin
      x = sb1.pop_front();
      check(1, x, o1, r1, b1, err1_w);
    end
    if (sb2.size() > 0) begin
      x = sb2.pop_front();
      check(2, x, o2, r2, b2, err2_w);
    end
  end

  // Present a letter and return one step after the edge that accepts it.
  task automatic send(input int dut, input logic [4:0] l, input string name);
    bit done;
    done = 1'b0;
    if (dut == 1) begin v1 = 1'b1; l1 = l; end
    else          begin v2 = 1'b1; l2 = l; end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if ((dut == 1) ? r1 : r2) done = 1'b1;
    end
    if (!done) begin
      tests++;
      errors++;
      $display("FAIL %s_accept dut%0d: got ready=0 for 100 cycles, want ready=1", name, dut);
    end
    @(posedge clk);
    #1;
    $display("[TB] dut%0d letter %0d (%s) accepted at t=%0t", dut, l, name, $time);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500 && (sb1.size() + sb2.size()) > 0; i++) @(negedge clk);
    if ((sb1.size() + sb2.size()) > 0) begin
      tests++;
      errors++;
      $display("FAIL %s_drain: got %0d pending entries, want 0", name, sb1.size() + sb2.size());
      sb1.delete();
      sb2.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish by 100000, want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset state: everything low while rst is high, ready rises after release.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_run(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, "in_reset");
    push_run(2, 1, 1'b0, 1'b0, 1'b0, 1'b0, "in_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "after_reset");
    push_run(2, 1, 1'b0, 1'b1, 1'b0, 1'b0, "after_reset");
    drain("reset");

    // U=1, E: 1,0,0,0 then idle.
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "E_idle");
    push_char(1, 1, ".", "E");
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "E_done");
    send(1, 5'd4, "E");
    v1 = 1'b0;
    drain("E");

    // U=2, A: 11 00 111111 000000.
    push_run(2, 1, 1'b0, 1'b1, 1'b0, 1'b0, "A_idle");
    push_char(2, 2, ".-", "A");
    push_run(2, 1, 1'b0, 1'b1, 1'b0, 1'b0, "A_done");
    send(2, 5'd0, "A");
    v2 = 1'b0;
    drain("A");

    // U=1, S O S back to back with valid held.
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "SOS_idle");
    push_char(1, 1, "...", "SOS_S1");
    push_char(1, 1, "---", "SOS_O");
    push_char(1, 1, "...", "SOS_S2");
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "SOS_done");
    send(1, 5'd18, "S");
    send(1, 5'd14, "O");
    send(1, 5'd18, "S");
    v1 = 1'b0;
    drain("SOS");

    // U=1, T, word space, E: 111, seven zeros, 1.
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "TSE_idle");
    push_char(1, 1, "-", "TSE_T");
    push_run(1, 3, 1'b0, 1'b0, 1'b1, 1'b0, "TSE_word");
    push_run(1, 1, 1'b0, 1'b1, 1'b1, 1'b0, "TSE_word_last");
    push_char(1, 1, ".", "TSE_E");
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "TSE_done");
    send(1, 5'd19, "T");
    send(1, 5'd26, "SPACE");
    send(1, 5'd4, "E");
    v1 = 1'b0;
    drain("TSE");

    // U=1, reset during the second dash of O, then a clean E.
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "RST_idle");
    push_run(1, 3, 1'b1, 1'b0, 1'b1, 1'b0, "RST_dash1");
    push_run(1, 1, 1'b0, 1'b0, 1'b1, 1'b0, "RST_gap");
    push_run(1, 2, 1'b1, 1'b0, 1'b1, 1'b0, "RST_dash2");
    push_run(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, "RST_held");
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "RST_released");
    send(1, 5'd14, "O_abort");
    v1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drain("RST");
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "RSTE_idle");
    push_char(1, 1, ".", "RSTE_E");
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "RSTE_done");
    send(1, 5'd4, "E_after_rst");
    v1 = 1'b0;
    drain("RSTE");

    // U=1, invalid code 30: consumed silently, err pulses once when enabled.
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b0, "INV_idle");
    push_run(1, 1, 1'b0, 1'b1, 1'b0, 1'b1, "INV_err");
    push_run(1, 2, 1'b0, 1'b1, 1'b0, 1'b0, "INV_after");
    send(1, 5'd30, "INVALID");
    v1 = 1'b0;
    drain("INV");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
